// File: rtl/udiv_pkg.sv
// Shared types and sizing for the sequential 2*DW/DW unsigned restoring divider.
package udiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 8;
  localparam int CNT_W      = $clog2(DW_DEFAULT);

endpackage

// File: rtl/udiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module udiv_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  logic [DW:0] t;

  // Trial subtraction; a set top remainder bit means the shifted value already exceeds any divisor.
  always_comb begin
    t = {rem_in[DW-1:0], bit_in};
    if (rem_in[DW] || (t >= {1'b0, divisor})) begin
      rem_out = t - {1'b0, divisor};
      q_bit   = 1'b1;
    end else begin
      rem_out = t;
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/seq_udiv_16by8.sv
// Sequential unsigned divider, 2*DW-bit dividend by DW-bit divisor, one quotient
// bit per cycle, valid/ready on both sides.
module seq_udiv_16by8
  import udiv_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic            ovf
);

  localparam int CW = (DW == DW_DEFAULT) ? CNT_W : $clog2(DW);

  state_t        state, next_state;
  logic [DW:0]   rem;
  logic [DW-1:0] quo;
  logic [DW-1:0] dvsr;
  logic [CW-1:0] cnt;
  logic [DW:0]   rem_next;
  logic          q_bit;
  logic          accept;
  logic          is_zero;
  logic          is_ovf;
  logic          last_step;

  assign accept    = in_valid & in_ready;
  assign is_zero   = (divisor == {DW{1'b0}});
  assign is_ovf    = (dividend[2*DW-1:DW] >= divisor);
  assign last_step = (cnt == CW'(DW - 1));

  udiv_step #(.DW(DW)) u_step (
    .rem_in  (rem),
    .bit_in  (quo[DW-1]),
    .divisor (dvsr),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register plus registered handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  // Next-state logic; special operands bypass CALC straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_zero || is_ovf) begin
            next_state = DONE;
          end else begin
            next_state = CALC;
          end
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (last_step) begin
          next_state = DONE;
        end else begin
          next_state = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers; results only change on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvsr <= divisor;
            if (is_zero) begin
              quotient  <= {DW{1'b1}};
              remainder <= dividend[DW-1:0];
              div_zero  <= 1'b1;
              ovf       <= 1'b0;
            end else if (is_ovf) begin
              quotient  <= {DW{1'b1}};
              remainder <= '0;
              div_zero  <= 1'b0;
              ovf       <= 1'b1;
            end else begin
              rem <= {1'b0, dividend[2*DW-1:DW]};
              quo <= dividend[DW-1:0];
              cnt <= '0;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= {quo[DW-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (last_step) begin
            quotient  <= {quo[DW-2:0], q_bit};
            remainder <= rem_next[DW-1:0];
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          rem <= rem;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_udiv_16by8.sv
// Directed and randomized checks of seq_udiv_16by8 against an arithmetic reference.
module tb_seq_udiv_16by8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_udiv_16by8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division with the saturating conventions for /0 and overflow.
  function automatic void model(input logic [15:0] n, input logic [7:0] d,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int unsigned qt;
    int unsigned rt;
    if (d == 8'd0) begin
      q = 8'hFF; r = n[7:0]; dz = 1'b1; ov = 1'b0;
    end else begin
      qt = 32'(n) / 32'(d);
      rt = 32'(n) % 32'(d);
      if (qt > 32'd255) begin
        q = 8'hFF; r = 8'h00; dz = 1'b0; ov = 1'b1;
      end else begin
        q = qt[7:0]; r = rt[7:0]; dz = 1'b0; ov = 1'b0;
      end
    end
  endfunction

  task automatic run_op(input logic [15:0] n, input logic [7:0] d, input int bp,
                        input bit noise, input string tag);
    logic [7:0]  eq, er;
    logic        edz, eov;
    int          lat;
    int          guard;
    int unsigned recon;
    model(n, d, eq, er, edz, eov);
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        dividend  = 16'($urandom);
        divisor   = 8'($urandom);
      end
      tick();
      lat++;
    end
    out_ready = 1'b0;
    chk({tag, " latency"}, 32'(lat), (edz || eov) ? 32'd0 : 32'd8);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
    chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eov});
    if (!edz && !eov) begin
      recon = 32'(quotient) * 32'(d) + 32'(remainder);
      chk({tag, " q*d+r"}, recon, 32'(n));
      chk({tag, " r<d"}, {31'd0, (remainder < d)}, 32'd1);
    end
    for (int i = 0; i < bp; i++) begin
      if (noise) begin
        in_valid = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      tick();
      chk({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, " hold quotient"}, {24'd0, quotient}, {24'd0, eq});
      chk({tag, " hold remainder"}, {24'd0, remainder}, {24'd0, er});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " release valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " release in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] n;
    logic [7:0]  d;
    int          sel;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'h0000;
    divisor   = 8'h00;
    #12;
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset quotient", {24'd0, quotient}, 32'd0);
    chk("reset remainder", {24'd0, remainder}, 32'd0);
    chk("reset flags", {30'd0, div_zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    run_op(16'h3039, 8'h7B, 0, 1'b0, "12345/123");
    run_op(16'h1234, 8'h00, 0, 1'b0, "div0");
    run_op(16'h8000, 8'h10, 0, 1'b0, "ovf");
    run_op(16'hFEFF, 8'hFF, 0, 1'b0, "maxlegal");
    run_op(16'h1000, 8'h20, 5, 1'b1, "backpressure");

    // Abort an operation after four CALC steps with an asynchronous reset.
    dividend = 16'h3039;
    divisor  = 8'h7B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort quotient", {24'd0, quotient}, 32'd0);
    chk("abort remainder", {24'd0, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("post-abort out_valid", {31'd0, out_valid}, 32'd0);
    run_op(16'd100, 8'd7, 0, 1'b0, "100/7");

    for (int k = 0; k < 4000; k++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0) begin
        d = 8'h00;
        n = 16'($urandom);
      end else if (sel == 1) begin
        d = 8'($urandom);
        n = 16'($urandom);
      end else begin
        d = 8'($urandom_range(1, 255));
        n = {8'($urandom_range(0, int'(d) - 1)), 8'($urandom)};
      end
      repeat ($urandom_range(0, 2)) tick();
      run_op(n, d, int'($urandom_range(0, 2)), 1'b1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
